// File: rtl/filter_config_scheduler.sv
// rtl/filter_config_scheduler.sv - frame-synchronous scheduler for the Filter_Pipe configuration word
//
// Arbitrates filter-mode change requests from the switch bank and the touch
// panel and commits at most one change per LTM_VD falling edge, so the pipe
// never changes mode mid-frame. After each commit a dwell of HOLD_FRAMES
// vsync edges must pass before the next commit can be scheduled.
//
// Parameters:
//   CFG_W        width of Filter_config (>= 6)
//   HOLD_FRAMES  vsync edges of dwell after a commit (>= 1)
//   FCNT_W       width of Frame_count
//
// Ports:
//   Clock          in   system clock
//   Resetn         in   synchronous, active-low reset
//   Enable         in   scheduler enable; low forces IDLE and drops requests
//   LTM_VD         in   LCD vertical sync, active low
//   Sw_req/Sw_cfg  in   1-cycle switch request and its 4-bit mode
//   Tp_req/Tp_cfg  in   1-cycle touch request and its 4-bit mode (wins ties)
//   Filter_config  out  committed configuration word
//   Cfg_update     out  1-cycle pulse in the cycle Filter_config changes
//   Busy           out  high while a request is pending or dwell is active
//   Frame_count    out  vsync falling edges seen while Enable=1 (wraps)
//
// Build option FILTER_CFG_SOURCE_TAG_EN: when defined, Filter_config[5:4]
// carries the source of the committed mode (01 switch, 10 touch).

module filter_config_scheduler #(
  parameter int CFG_W       = 32,
  parameter int HOLD_FRAMES = 2,
  parameter int FCNT_W      = 16
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Enable,
  input  logic              LTM_VD,
  input  logic              Sw_req,
  input  logic [3:0]        Sw_cfg,
  input  logic              Tp_req,
  input  logic [3:0]        Tp_cfg,
  output logic [CFG_W-1:0]  Filter_config,
  output logic              Cfg_update,
  output logic              Busy,
  output logic [FCNT_W-1:0] Frame_count
);

  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    APPLY   = 2'd2,
    HOLD    = 2'd3
  } state_t;

  state_t           state;
  logic             vd_q;
  logic             vs_edge;
  logic             pending;
  logic             pend_tp;
  logic [3:0]       pend_cfg;
  logic [HW-1:0]    hold_cnt;
  logic             pend_live;
  logic [3:0]       cur_cfg;
  logic             take_tp;
  logic             take_sw;
  logic [CFG_W-1:0] commit_word;

  // First cycle LTM_VD is seen low.
  assign vs_edge = vd_q & ~LTM_VD;

  // In APPLY the latched request is being consumed this cycle: it no longer
  // blocks or shields a new request, and the mode it is about to become is
  // the reference for dropping duplicates.
  assign pend_live = pending & (state != APPLY);
  assign cur_cfg   = (state == APPLY) ? pend_cfg : Filter_config[3:0];

  // A duplicate of the current mode with nothing pending is dropped.
  // A pending touch request is never displaced by a switch request.
  assign take_tp = pend_live | (Tp_cfg != cur_cfg);
  assign take_sw = ~(pend_live & pend_tp) & (pend_live | (Sw_cfg != cur_cfg));

  assign Busy = (state != IDLE) | pending;

  always_comb begin
    commit_word      = '0;
    commit_word[3:0] = pend_cfg;
`ifdef FILTER_CFG_SOURCE_TAG_EN
    commit_word[5:4] = pend_tp ? 2'b10 : 2'b01;
`endif
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state         <= IDLE;
      vd_q          <= 1'b1;
      pending       <= 1'b0;
      pend_tp       <= 1'b0;
      pend_cfg      <= 4'h0;
      hold_cnt      <= '0;
      Filter_config <= '0;
      Cfg_update    <= 1'b0;
      Frame_count   <= '0;
    end else begin
      vd_q       <= LTM_VD;
      Cfg_update <= 1'b0;

      if (!Enable) begin
        state    <= IDLE;
        pending  <= 1'b0;
        pend_tp  <= 1'b0;
        pend_cfg <= 4'h0;
        hold_cnt <= '0;
      end else begin
        if (vs_edge) begin
          Frame_count <= Frame_count + FCNT_W'(1);
        end

        case (state)
          IDLE: begin
            if (pending) begin
              state <= PENDING;
            end
          end
          PENDING: begin
            if (vs_edge) begin
              state <= APPLY;
            end
          end
          APPLY: begin
            Filter_config <= commit_word;
            Cfg_update    <= 1'b1;
            pending       <= 1'b0;
            hold_cnt      <= HW'(HOLD_FRAMES - 1);
            state         <= HOLD;
          end
          HOLD: begin
            if (vs_edge) begin
              if (hold_cnt == '0) begin
                state <= pending ? PENDING : IDLE;
              end else begin
                hold_cnt <= hold_cnt - HW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase

        // Placed after the FSM so a request arriving during APPLY survives
        // the pending clear of the commit it follows.
        if (Tp_req) begin
          if (take_tp) begin
            pending  <= 1'b1;
            pend_tp  <= 1'b1;
            pend_cfg <= Tp_cfg;
          end
        end else if (Sw_req) begin
          if (take_sw) begin
            pending  <= 1'b1;
            pend_tp  <= 1'b0;
            pend_cfg <= Sw_cfg;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_config_scheduler.sv
// tb/tb_filter_config_scheduler.sv - scoreboard bench for filter_config_scheduler

module tb_filter_config_scheduler;

  localparam int CFG_W       = 32;
  localparam int HOLD_FRAMES = 2;
  localparam int FCNT_W      = 16;

`ifdef FILTER_CFG_SOURCE_TAG_EN
  localparam logic [31:0] EXP1  = 32'h13;
  localparam logic [31:0] EXP2  = 32'h29;
  localparam logic [31:0] EXP3A = 32'h11;
  localparam logic [31:0] EXP3B = 32'h12;
`else
  localparam logic [31:0] EXP1  = 32'h3;
  localparam logic [31:0] EXP2  = 32'h9;
  localparam logic [31:0] EXP3A = 32'h1;
  localparam logic [31:0] EXP3B = 32'h2;
`endif

  logic              Clock;
  logic              Resetn;
  logic              Enable;
  logic              LTM_VD;
  logic              Sw_req;
  logic [3:0]        Sw_cfg;
  logic              Tp_req;
  logic [3:0]        Tp_cfg;
  logic [CFG_W-1:0]  Filter_config;
  logic              Cfg_update;
  logic              Busy;
  logic [FCNT_W-1:0] Frame_count;

  logic [CFG_W-1:0]  s_filter_config;
  logic              s_cfg_update;
  logic              s_busy;
  logic [7:0]        s_frame_count;

  filter_config_scheduler #(
    .CFG_W(CFG_W), .HOLD_FRAMES(HOLD_FRAMES), .FCNT_W(FCNT_W)
  ) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .LTM_VD(LTM_VD),
    .Sw_req(Sw_req), .Sw_cfg(Sw_cfg), .Tp_req(Tp_req), .Tp_cfg(Tp_cfg),
    .Filter_config(Filter_config), .Cfg_update(Cfg_update), .Busy(Busy),
    .Frame_count(Frame_count)
  );

  // Narrow frame counter instance so the wrap can be reached quickly.
  filter_config_scheduler #(
    .CFG_W(CFG_W), .HOLD_FRAMES(HOLD_FRAMES), .FCNT_W(8)
  ) dut_small (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .LTM_VD(LTM_VD),
    .Sw_req(Sw_req), .Sw_cfg(Sw_cfg), .Tp_req(Tp_req), .Tp_cfg(Tp_cfg),
    .Filter_config(s_filter_config), .Cfg_update(s_cfg_update), .Busy(s_busy),
    .Frame_count(s_frame_count)
  );

  initial Clock = 1'b0;
  always #10 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level) ----------------
  typedef struct {
    logic [CFG_W-1:0] word;
    int               at;
  } exp_t;

  exp_t             exp_q[$];
  logic [CFG_W-1:0] m_cfg  = '0;
  bit               m_pend = 0;
  bit               m_ptp  = 0;
  logic [3:0]       m_pcfg = 4'h0;
  int               m_wait = 0;
  logic [15:0]      m_fcnt = 16'h0;
  bit               m_en   = 0;

  function automatic logic [CFG_W-1:0] mk_word(input logic [3:0] c, input bit tp);
    logic [CFG_W-1:0] w;
    w      = '0;
    w[3:0] = c;
`ifdef FILTER_CFG_SOURCE_TAG_EN
    w[5:4] = tp ? 2'b10 : 2'b01;
`endif
    return w;
  endfunction

  task automatic model_req(input bit sw, input logic [3:0] swc, input bit tp, input logic [3:0] tpc);
    if (!m_en) return;
    if (tp) begin
      if (m_pend || tpc != m_cfg[3:0]) begin
        m_pend = 1; m_ptp = 1; m_pcfg = tpc;
      end
    end else if (sw) begin
      if (!(m_pend && m_ptp) && (m_pend || swc != m_cfg[3:0])) begin
        m_pend = 1; m_ptp = 0; m_pcfg = swc;
      end
    end
  endtask

  // Called when LTM_VD is driven low; the commit becomes visible two clocks later.
  task automatic model_edge();
    exp_t e;
    if (!m_en) return;
    m_fcnt = m_fcnt + 16'h1;
    if (m_wait > 0) begin
      m_wait--;
    end else if (m_pend) begin
      m_cfg  = mk_word(m_pcfg, m_ptp);
      e.word = m_cfg;
      e.at   = cyc + 2;
      exp_q.push_back(e);
      m_pend = 0;
      m_wait = HOLD_FRAMES;
    end
  endtask

  task automatic model_reset();
    m_cfg = '0; m_pend = 0; m_ptp = 0; m_wait = 0; m_fcnt = 16'h0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (Cfg_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_cfg_update actual=%0h required=no_pulse", Filter_config);
      end else begin
        e = exp_q.pop_front();
        chk("commit_word", Filter_config, e.word);
        chk("commit_cycle", cyc, e.at);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic req(input bit sw, input logic [3:0] swc, input bit tp, input logic [3:0] tpc);
    Sw_req = sw; Sw_cfg = swc; Tp_req = tp; Tp_cfg = tpc;
    model_req(sw, swc, tp, tpc);
    step();
    Sw_req = 1'b0; Tp_req = 1'b0;
  endtask

  task automatic set_en(input bit e);
    Enable = e;
    if (e) m_en = 1;
    else begin m_en = 0; m_pend = 0; m_wait = 0; end
    step();
  endtask

  task automatic vs_fall();
    repeat (3) step();
    LTM_VD = 1'b0;
    model_edge();
    step();
    step();
    LTM_VD = 1'b1;
    repeat (4) step();
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_cfg"}, Filter_config, m_cfg);
    chk({tag, "_busy"}, Busy, (m_pend || m_wait > 0));
    chk({tag, "_fcnt"}, Frame_count, m_fcnt);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    Resetn = 1'b0; Enable = 1'b0; LTM_VD = 1'b1;
    Sw_req = 1'b0; Sw_cfg = 4'h0; Tp_req = 1'b0; Tp_cfg = 4'h0;
    repeat (3) step();
    chk("reset_cfg", Filter_config, 32'h0);
    chk("reset_upd", Cfg_update, 1'b0);
    chk("reset_busy", Busy, 1'b0);
    chk("reset_fcnt", Frame_count, 16'h0);
    Resetn = 1'b1;
    set_en(1);

    // mid-frame request waits for the vsync fall
    repeat (5) step();
    req(1, 4'h3, 0, 4'h0);
    chk("t1_busy", Busy, 1'b1);
    repeat (4) step();
    chk("t1_hold_cfg", Filter_config, 32'h0);
    vs_fall();
    chk("t1_cfg", Filter_config, EXP1);
    check_model("t1");
    repeat (3) vs_fall();

    // duplicate of current mode is dropped
    req(1, 4'h3, 0, 4'h0);
    chk("t4_busy", Busy, 1'b0);
    vs_fall();
    vs_fall();
    chk("t4_cfg", Filter_config, EXP1);
    check_model("t4");

    // touch wins a same-cycle tie
    req(1, 4'h5, 1, 4'h9);
    vs_fall();
    chk("t2_cfg", Filter_config, EXP2);
    repeat (3) vs_fall();

    // dwell between commits
    req(1, 4'h1, 0, 4'h0);
    vs_fall();
    chk("t3_cfg0", Filter_config, EXP3A);
    req(1, 4'h2, 0, 4'h0);
    chk("t3_busy0", Busy, 1'b1);
    vs_fall();
    chk("t3_cfg1", Filter_config, EXP3A);
    chk("t3_busy1", Busy, 1'b1);
    vs_fall();
    chk("t3_cfg2", Filter_config, EXP3A);
    chk("t3_busy2", Busy, 1'b1);
    vs_fall();
    chk("t3_cfg3", Filter_config, EXP3B);
    check_model("t3");
    repeat (3) vs_fall();

    // Enable dropped while pending
    req(1, 4'h7, 0, 4'h0);
    chk("t5_busy_on", Busy, 1'b1);
    set_en(0);
    chk("t5_busy_off", Busy, 1'b0);
    vs_fall();
    chk("t5_cfg", Filter_config, EXP3B);
    check_model("t5_dis");
    set_en(1);
    begin
      logic [15:0] f0;
      f0 = m_fcnt;
      repeat (3) vs_fall();
      chk("t5_fcnt3", Frame_count, f0 + 16'h3);
    end

    // reset during HOLD
    req(1, 4'h4, 0, 4'h0);
    vs_fall();
    check_model("t6_pre");
    Resetn = 1'b0;
    step();
    model_reset();
    Resetn = 1'b1;
    chk("t6_cfg", Filter_config, 32'h0);
    chk("t6_upd", Cfg_update, 1'b0);
    chk("t6_busy", Busy, 1'b0);
    chk("t6_fcnt", Frame_count, 16'h0);
    vs_fall();
    check_model("t6_post");

    // frame counter wrap on the narrow instance
    while (m_fcnt != 16'h00FF) begin
      LTM_VD = 1'b0; model_edge(); step();
      LTM_VD = 1'b1; step();
    end
    chk("wrap_small_ff", s_frame_count, 8'hFF);
    chk("wrap_main_ff", Frame_count, 16'h00FF);
    LTM_VD = 1'b0; model_edge(); step();
    LTM_VD = 1'b1; step();
    chk("wrap_small_0", s_frame_count, 8'h00);
    chk("wrap_main_100", Frame_count, 16'h0100);

    // randomized traffic
    for (int f = 0; f < 40; f++) begin
      vs_fall();
      check_model("rnd");
      for (int i = 0; i < 8; i++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 5) begin
          int k;
          logic [3:0] a, b;
          k = $urandom_range(0, 2);
          a = 4'($urandom_range(0, 3));
          b = 4'($urandom_range(0, 3));
          req(k != 1, a, k != 0, b);
        end else if (r == 19) begin
          set_en(!Enable);
        end else begin
          step();
        end
      end
      if (!Enable) set_en(1);
    end
    repeat (3) vs_fall();
    check_model("final");

    repeat (10) step();
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
